// File: rtl/l2_request_arbiter_if.sv
// Purpose: bundles the L1 requester side and the riscv L2 FIFO side of the L2 request arbiter.
// Latency: none; this is wiring only.
// Backpressure: to_cpu_addr_full / to_cpu_data_full and the wdata_valid/wdata_pop pair travel here.
//
// Modports:
//   master - the arbiter. It takes requests, write data, FIFO status and responses.
//            It drives acks, pops, pushes, response strobes and SC results.
//   slave  - the environment (L1 requesters plus the riscv FIFOs). Its directions are the reverse.
interface l2_request_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // L1 requester side
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][29:0] req_addr;
    logic [NUM_REQ-1:0]       req_rnw;
    logic [NUM_REQ-1:0][3:0]  req_be;
    logic [NUM_REQ-1:0]       req_is_amo;
    logic [NUM_REQ-1:0][4:0]  req_amo_type;
    logic [NUM_REQ-1:0][2:0]  req_size;
    logic [NUM_REQ-1:0]       req_ack;
    logic [NUM_REQ-1:0][31:0] wdata;
    logic [NUM_REQ-1:0]       wdata_valid;
    logic [NUM_REQ-1:0]       wdata_pop;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [31:0]              rsp_data;
    logic                     sc_complete;
    logic                     sc_success;

    // riscv L2 FIFO side
    logic        from_cpu_addr_push;
    logic [45:0] from_cpu_addr_data;
    logic        to_cpu_addr_full;
    logic        from_cpu_data_push;
    logic [31:0] from_cpu_data_data;
    logic        to_cpu_data_full;
    logic        from_cpu_data_pop;
    logic [33:0] to_cpu_data_data;
    logic        to_cpu_data_valid;
    logic        from_cpu_con_pop;
    logic        to_cpu_con_data;
    logic        to_cpu_con_valid;

    modport master (
        input  req_valid, req_addr, req_rnw, req_be, req_is_amo, req_amo_type, req_size,
        input  wdata, wdata_valid,
        input  to_cpu_addr_full, to_cpu_data_full,
        input  to_cpu_data_data, to_cpu_data_valid, to_cpu_con_data, to_cpu_con_valid,
        output req_ack, wdata_pop, rsp_valid, rsp_data, sc_complete, sc_success,
        output from_cpu_addr_push, from_cpu_addr_data,
        output from_cpu_data_push, from_cpu_data_data,
        output from_cpu_data_pop, from_cpu_con_pop
    );

    modport slave (
        output req_valid, req_addr, req_rnw, req_be, req_is_amo, req_amo_type, req_size,
        output wdata, wdata_valid,
        output to_cpu_addr_full, to_cpu_data_full,
        output to_cpu_data_data, to_cpu_data_valid, to_cpu_con_data, to_cpu_con_valid,
        input  req_ack, wdata_pop, rsp_valid, rsp_data, sc_complete, sc_success,
        input  from_cpu_addr_push, from_cpu_addr_data,
        input  from_cpu_data_push, from_cpu_data_data,
        input  from_cpu_data_pop, from_cpu_con_pop
    );
endinterface

// File: rtl/l2_request_arbiter.sv
// Purpose: shares the L2 request channel between the L1 requesters and routes L2 responses back to them.
// Latency: the grant/ack/push fires in the same cycle a request is seen. Write data follows from the next cycle, one word per cycle.
// Backpressure: a full address FIFO holds requests pending. A full data FIFO or a missing wdata_valid stalls the burst.
//
// Ports: clk, rst (synchronous, active high). bus is an l2_request_arbiter_if.master carrying all
// requester and FIFO signals. NUM_REQ must not exceed 4 because the ID field is 2 bits.
// Define L2_ARB_ROUND_ROBIN_EN to get round-robin winner selection. Without it, fixed priority
// applies and index 0 (icache) wins.
module l2_request_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_request_arbiter_if.master bus
);
    localparam int ID_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] grant;     // owner of the write burst in progress
    logic [2:0]      count;     // data words left after the current one
    logic [ID_W-1:0] win;
    logic            win_found;
    logic            grant_fire;
    logic            data_fire;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef L2_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W:0]   cand;

    // Walk from the farthest candidate back to rr_ptr. The request closest to the pointer is then the last one written, so it wins.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (bus.req_valid[cand[ID_W-1:0]]) begin
                win       = cand[ID_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_fire) begin
            rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
        end
    end
`else
    // Fixed priority. Scanning downward leaves the lowest pending index as the winner.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win       = ID_W'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    // Qualifiers are gated by rst so that nothing is acked, pushed or popped in the reset cycle.
    assign grant_fire = !rst && (state == IDLE) && win_found && !bus.to_cpu_addr_full;
    assign data_fire  = !rst && (state == WDATA) && bus.wdata_valid[grant] && !bus.to_cpu_data_full;

    // ------------------------------------------------------------------
    // State register plus burst bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (grant_fire) begin
                grant <= win;
                // Only writes (including write AMOs) use count.
                if (!bus.req_rnw[win]) begin
                    count <= bus.req_size[win];
                end
            end else if (data_fire && count != 3'd0) begin
                count <= count - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_fire && !bus.req_rnw[win]) begin
                    state_nxt = WDATA;
                end
            end
            WDATA: begin
                if (data_fire && count == 3'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: request/write path from the FSM, response/SC paths in every state
    // ------------------------------------------------------------------
    always_comb begin
        bus.req_ack            = '0;
        bus.wdata_pop          = '0;
        bus.from_cpu_addr_push = 1'b0;
        bus.from_cpu_addr_data = '0;
        bus.from_cpu_data_push = 1'b0;
        bus.from_cpu_data_data = '0;
        bus.rsp_valid          = '0;
        bus.rsp_data           = '0;
        bus.from_cpu_data_pop  = 1'b0;
        bus.from_cpu_con_pop   = 1'b0;
        bus.sc_complete        = 1'b0;
        bus.sc_success         = 1'b0;

        if (grant_fire) begin
            bus.req_ack[win]       = 1'b1;
            bus.from_cpu_addr_push = 1'b1;
            bus.from_cpu_addr_data = {bus.req_addr[win], bus.req_be[win], bus.req_rnw[win],
                                      bus.req_is_amo[win], bus.req_amo_type[win],
                                      bus.req_size[win], win};
        end

        if (data_fire) begin
            bus.wdata_pop[grant]   = 1'b1;
            bus.from_cpu_data_push = 1'b1;
            bus.from_cpu_data_data = bus.wdata[grant];
        end

        if (!rst) begin
            // Requesters always accept, so a valid return is popped at once.
            bus.from_cpu_data_pop = bus.to_cpu_data_valid;
            bus.rsp_data          = bus.to_cpu_data_data[31:0];
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.rsp_valid[i] = bus.to_cpu_data_valid &&
                                   (bus.to_cpu_data_data[33:32] == ID_W'(i));
            end
            bus.from_cpu_con_pop = bus.to_cpu_con_valid;
            bus.sc_complete      = bus.to_cpu_con_valid;
            bus.sc_success       = bus.to_cpu_con_data;
        end
    end

endmodule
